glitch_filter: RTL and testbench
================================

// Module: glitch_filter
// PURPOSE
//  Downstream consumer of the combinational glitch-prone logic output x (x = a&~b&c | ~c&d).
//  Synchronises x into the clk domain and rejects pulses shorter than STABLE_CYCLES samples.
//  Outputs a clean level, one-cycle rise/fall strobes and a saturating count of rejected glitches.
//  Sits between the asynchronous combinational logic and any clocked logic that uses x.
// PARAMETERS
//  SYNC_STAGES    2  synchroniser flops on x_in (legal >=2)
//  STABLE_CYCLES  4  consecutive equal synced samples required to change x_clean (legal >=2)
//  GCNT_W         8  width of glitch_cnt
// PORTS
//  clk         in   1       rising-edge clock
//  rst_n       in   1       synchronous active-low reset, sampled on rising clk
//  en          in   1       filter enable
//  x_in        in   1       asynchronous, glitchy input from the combinational stage
//  x_clean     out  1       filtered, registered level
//  rise_pulse  out  1       one-cycle strobe when x_clean goes 0->1
//  fall_pulse  out  1       one-cycle strobe when x_clean goes 1->0
//  busy        out  1       1 while state is ST_CONF_H or ST_CONF_L
//  glitch_cnt  out  GCNT_W  rejected-pulse count, saturating
// BEHAVIOUR
//  Reset: clk and active-low synchronous rst_n only. On the rst_n=0 edge, all of these clear:
//   sync flops, x_clean, rise_pulse, fall_pulse, busy, glitch_cnt and cnt. State goes to ST_LOW.
//   Reset mid-confirmation aborts it and does not count a glitch.
//  x_s is the last sync flop. All outputs are registered.
//  FSM state transitions:
//   ST_LOW:    x_s=1 -> ST_CONF_H, cnt<=1
//   ST_CONF_H: x_s=1, cnt==STABLE_CYCLES-1 -> ST_HIGH, x_clean<=1, rise_pulse<=1
//              x_s=1, otherwise -> cnt<=cnt+1
//              x_s=0 -> ST_LOW, cnt<=0, glitch_cnt<=glitch_cnt+1 (saturates at all-ones)
//   ST_HIGH:   x_s=0 -> ST_CONF_L, cnt<=1
//   ST_CONF_L: mirror of ST_CONF_H with x_s inverted; success -> ST_LOW, x_clean<=0, fall_pulse<=1
//  Pulses are high for exactly one cycle. rise_pulse and fall_pulse are never both 1.
//  Latency: count the first edge that samples the new x_in as edge 1.
//   x_clean changes on edge SYNC_STAGES+STABLE_CYCLES (6 with defaults). The strobe is on that same edge.
//  A synced pulse shorter than STABLE_CYCLES samples is rejected.
//   x_clean is unchanged, the glitch counts once, and no strobe is issued.
//  en=0:
//   ST_CONF_H -> ST_LOW and ST_CONF_L -> ST_HIGH, cnt<=0. No glitch is counted and no strobe is issued.
//   Settled states hold. The sync chain keeps sampling.
//   The first cycle with en=1 evaluates x_s normally.
//  cnt width is $clog2(STABLE_CYCLES+1). It never exceeds STABLE_CYCLES-1.
//  glitch_cnt only clears on reset.
//  Elaboration: $error if SYNC_STAGES<2 or STABLE_CYCLES<2.
// STRUCTURE
//  Package glitch_filter_pkg:
//   typedef enum logic [1:0] {ST_LOW, ST_CONF_H, ST_HIGH, ST_CONF_L} gf_state_t
//   default parameter constants
//  Sub-module sync_chain #(STAGES): n-flop synchroniser with synchronous active-low reset to 0.
//  Top: one always_ff for state, cnt, outputs and glitch_cnt. Next-state logic in always_comb.
// TESTING
//  T1 reset: rst_n=0 for 2 cycles with x_in=1 -> x_clean=0, glitch_cnt=0, no strobes.
//   After release, x_clean=1 on edge 6 and rise_pulse=1 for that one cycle only.
//  T2 glitch reject: x_in=1 for 2 cycles from LOW -> x_clean stays 0, glitch_cnt=1, busy high 2 cycles.
//   Four such pulses -> glitch_cnt=4.
//  T3 clean toggle: x_in 0->1 held 10 cycles, then 1->0 held 10 cycles ->
//   rise_pulse and fall_pulse once each, each 6 cycles after its x_in edge.
//  T4 sub-cycle glitch: drive x = a&~b&c | ~c&d with #2 gate delays at a 10ns clk.
//   Step c 1->0 with a=1, b=0, d=1 -> x_clean stays 1, glitch_cnt<=1, no fall_pulse.
//  T5 enable abort: enter ST_CONF_H, drop en at cnt=2 -> state ST_LOW, glitch_cnt unchanged.
//   Re-enable with x_in still 1 -> full STABLE_CYCLES confirmation is required again.
//  T6 saturation: GCNT_W=2, 5 rejected pulses -> glitch_cnt=3 and held there.

Source files
------------

// File: rtl/glitch_filter_pkg.sv
// Shared types and default sizing for the glitch filter slice.
package glitch_filter_pkg;

  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    ST_CONF_H = 2'd1,
    ST_HIGH   = 2'd2,
    ST_CONF_L = 2'd3
  } gf_state_t;

  localparam int unsigned DEF_SYNC_STAGES   = 2;
  localparam int unsigned DEF_STABLE_CYCLES = 4;
  localparam int unsigned DEF_GCNT_W        = 8;

endpackage

// File: rtl/glitch_filter_sync_chain.sv
// Multi-flop synchroniser bringing an asynchronous level into the clk domain.
module sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_chain: STAGES must be >= 2");
  end

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/glitch_filter.sv
// Synchronises a glitch-prone combinational level and only lets it change after
// STABLE_CYCLES consecutive agreeing samples; short pulses are counted as glitches.
module glitch_filter
  import glitch_filter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned GCNT_W        = DEF_GCNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              x_in,
  output logic              x_clean,
  output logic              rise_pulse,
  output logic              fall_pulse,
  output logic              busy,
  output logic [GCNT_W-1:0] glitch_cnt
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("glitch_filter: SYNC_STAGES must be >= 2");
  end
  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $error("glitch_filter: STABLE_CYCLES must be >= 2");
  end

  logic x_s;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (x_in),
    .q     (x_s)
  );

  gf_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              x_clean_d, rise_d, fall_d, busy_d;
  logic [GCNT_W-1:0] glitch_d, glitch_inc;

  assign glitch_inc = (glitch_cnt == '1) ? glitch_cnt : glitch_cnt + GCNT_W'(1);

  // Next state: a confirm state either completes, advances, or falls back as a glitch
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    x_clean_d = x_clean;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    glitch_d  = glitch_cnt;
    case (state_q)
      ST_LOW: begin
        if (en && x_s) begin
          state_d = ST_CONF_H;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_CONF_H: begin
        if (!en) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (x_s) begin
          if (cnt_q == CNT_LAST) begin
            state_d   = ST_HIGH;
            cnt_d     = '0;
            x_clean_d = 1'b1;
            rise_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d  = ST_LOW;
          cnt_d    = '0;
          glitch_d = glitch_inc;
        end
      end
      ST_HIGH: begin
        if (en && !x_s) begin
          state_d = ST_CONF_L;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_CONF_L: begin
        if (!en) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (!x_s) begin
          if (cnt_q == CNT_LAST) begin
            state_d   = ST_LOW;
            cnt_d     = '0;
            x_clean_d = 1'b0;
            fall_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d  = ST_HIGH;
          cnt_d    = '0;
          glitch_d = glitch_inc;
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == ST_CONF_H) || (state_d == ST_CONF_L);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_LOW;
      cnt_q      <= '0;
      x_clean    <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      busy       <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      x_clean    <= x_clean_d;
      rise_pulse <= rise_d;
      fall_pulse <= fall_d;
      busy       <= busy_d;
      glitch_cnt <= glitch_d;
    end
  end

endmodule

// File: tb/tb_glitch_filter.sv
// Bench for glitch_filter: directed scenarios plus randomized traffic against a run-length model.
module tb_glitch_filter;
  import glitch_filter_pkg::*;

  localparam int unsigned SYNC   = DEF_SYNC_STAGES;
  localparam int unsigned STABLE = DEF_STABLE_CYCLES;

  logic clk = 1'b0;
  logic rst_n, en, x_drv, use_gates;
  logic a, b, c, d, nb, nc, t1, t2, x_gate;
  logic x_in;

  logic       x_clean, rise_pulse, fall_pulse, busy;
  logic [7:0] glitch_cnt;
  logic       x_clean_s, rise_s, fall_s, busy_s;
  logic [1:0] glitch_cnt_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // x = a&~b&c | ~c&d built from delayed gates so a c edge produces a real hazard
  assign #2 nb     = ~b;
  assign #2 nc     = ~c;
  assign #2 t1     = a & nb & c;
  assign #2 t2     = nc & d;
  assign #2 x_gate = t1 | t2;
  assign x_in = use_gates ? x_gate : x_drv;

  glitch_filter dut (
    .clk(clk), .rst_n(rst_n), .en(en), .x_in(x_in),
    .x_clean(x_clean), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .busy(busy), .glitch_cnt(glitch_cnt)
  );

  glitch_filter #(.GCNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .x_in(x_in),
    .x_clean(x_clean_s), .rise_pulse(rise_s), .fall_pulse(fall_s),
    .busy(busy_s), .glitch_cnt(glitch_cnt_s)
  );

  // Reference: delay x_in by SYNC samples, then count consecutive samples that disagree with the clean level
  logic [SYNC-1:0] m_sync;
  logic m_clean, m_rise, m_fall;
  int   m_pend, m_glitch;

  always @(posedge clk) begin : model
    logic xs;
    int   pend, gl;
    logic cl, r, f;
    if (!rst_n) begin
      m_sync <= '0; m_clean <= 1'b0; m_rise <= 1'b0; m_fall <= 1'b0;
      m_pend <= 0;  m_glitch <= 0;
    end else begin
      xs = m_sync[SYNC-1];
      pend = m_pend; gl = m_glitch; cl = m_clean; r = 1'b0; f = 1'b0;
      if (!en) pend = 0;
      else if (xs != cl) begin
        pend = pend + 1;
        if (pend == STABLE) begin
          cl = xs; r = xs; f = !xs; pend = 0;
        end
      end else if (pend > 0) begin
        gl = gl + 1; pend = 0;
      end
      m_sync   <= {m_sync[SYNC-2:0], x_in};
      m_pend   <= pend; m_glitch <= gl; m_clean <= cl;
      m_rise   <= r;    m_fall   <= f;
    end
  end

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic do_reset(input logic xv);
    @(negedge clk);
    x_drv = xv; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse(input int unsigned n);
    x_drv = 1'b1;
    repeat (n) @(negedge clk);
    x_drv = 1'b0;
  endtask

  task automatic test_reset;
    x_drv = 1'b1; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({x_clean, rise_pulse, fall_pulse, busy, glitch_cnt} !== 12'h0) begin
      n_errors++;
      $display("FAIL reset_state: got clean=%b rise=%b fall=%b busy=%b gcnt=%0d expected all 0",
               x_clean, rise_pulse, fall_pulse, busy, glitch_cnt);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      n_checks++;
      if (x_clean !== (k >= 6) || rise_pulse !== (k == 6) || fall_pulse !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_release_edge%0d: got clean=%b rise=%b fall=%b expected clean=%b rise=%b fall=0",
                 k, x_clean, rise_pulse, fall_pulse, k >= 6, k == 6);
      end
    end
  endtask

  task automatic test_glitch_reject;
    int busy_cycles;
    do_reset(1'b0);
    repeat (4) @(negedge clk);
    for (int p = 1; p <= 4; p++) begin
      busy_cycles = 0;
      pulse(2);
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (busy === 1'b1) busy_cycles++;
        n_checks++;
        if (x_clean !== 1'b0 || rise_pulse !== 1'b0) begin
          n_errors++;
          $display("FAIL glitch_level: got clean=%b rise=%b expected 0 0", x_clean, rise_pulse);
        end
      end
      n_checks++;
      if (glitch_cnt !== 8'(p) || busy_cycles != 2) begin
        n_errors++;
        $display("FAIL glitch_count%0d: got gcnt=%0d busy_cycles=%0d expected gcnt=%0d busy_cycles=2",
                 p, glitch_cnt, busy_cycles, p);
      end
    end
  endtask

  task automatic test_clean_toggle;
    for (int dir = 1; dir >= 0; dir--) begin
      x_drv = 1'(dir);
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk);
        n_checks++;
        if (rise_pulse !== (dir == 1 && k == 6) || fall_pulse !== (dir == 0 && k == 6) ||
            x_clean !== ((k >= 6) ? 1'(dir) : 1'(!dir))) begin
          n_errors++;
          $display("FAIL toggle_dir%0d_edge%0d: got clean=%b rise=%b fall=%b", dir, k,
                   x_clean, rise_pulse, fall_pulse);
        end
      end
    end
  endtask

  task automatic test_subcycle_glitch;
    int g0;
    a = 1'b1; b = 1'b0; c = 1'b1; d = 1'b1;
    x_drv = 1'b1;
    repeat (10) @(negedge clk);
    use_gates = 1'b1;
    repeat (2) @(negedge clk);
    g0 = int'(glitch_cnt);
    c = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++;
      if (x_clean !== 1'b1 || fall_pulse !== 1'b0) begin
        n_errors++;
        $display("FAIL subcycle_level: got clean=%b fall=%b expected 1 0", x_clean, fall_pulse);
      end
    end
    n_checks++;
    if (int'(glitch_cnt) > g0 + 1 || int'(glitch_cnt) != sat(m_glitch, 255)) begin
      n_errors++;
      $display("FAIL subcycle_gcnt: got %0d expected %0d (start %0d)", glitch_cnt, sat(m_glitch, 255), g0);
    end
    x_drv = 1'b1;
    use_gates = 1'b0;
    c = 1'b1;
  endtask

  task automatic test_enable_abort;
    int g0;
    do_reset(1'b0);
    repeat (4) @(negedge clk);
    g0 = int'(glitch_cnt);
    x_drv = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL abort_confirming: got busy=%b expected 1", busy);
    end
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || x_clean !== 1'b0 || int'(glitch_cnt) != g0) begin
        n_errors++;
        $display("FAIL abort_hold: got busy=%b clean=%b gcnt=%0d expected 0 0 %0d",
                 busy, x_clean, glitch_cnt, g0);
      end
    end
    en = 1'b1;
    for (int k = 1; k <= int'(STABLE); k++) begin
      @(negedge clk);
      n_checks++;
      if (x_clean !== (k == int'(STABLE)) || rise_pulse !== (k == int'(STABLE)) ||
          busy !== (k != int'(STABLE))) begin
        n_errors++;
        $display("FAIL reenable_edge%0d: got clean=%b rise=%b busy=%b", k, x_clean, rise_pulse, busy);
      end
    end
  endtask

  task automatic test_saturation;
    do_reset(1'b0);
    repeat (4) @(negedge clk);
    for (int p = 1; p <= 7; p++) begin
      pulse(2);
      repeat (6) @(negedge clk);
      if (p == 5 || p == 7) begin
        n_checks++;
        if (glitch_cnt_s !== 2'd3 || glitch_cnt !== 8'(p)) begin
          n_errors++;
          $display("FAIL saturation_p%0d: got sat=%0d main=%0d expected sat=3 main=%0d",
                   p, glitch_cnt_s, glitch_cnt, p);
        end
      end
    end
  endtask

  task automatic test_random;
    int run = 0;
    for (int i = 0; i < 2000; i++) begin
      if (run == 0) begin
        x_drv = 1'($urandom_range(0, 1));
        run = $urandom_range(1, 7);
      end
      run--;
      en    = ($urandom_range(0, 15) != 0);
      rst_n = ($urandom_range(0, 199) != 0);
      @(negedge clk);
      n_checks++;
      if (x_clean !== m_clean || rise_pulse !== m_rise || fall_pulse !== m_fall ||
          busy !== (m_pend != 0) || int'(glitch_cnt) != sat(m_glitch, 255) ||
          int'(glitch_cnt_s) != sat(m_glitch, 3) || x_clean_s !== m_clean) begin
        n_errors++;
        $display("FAIL random_cycle%0d: got clean=%b rise=%b fall=%b busy=%b gcnt=%0d sat=%0d expected clean=%b rise=%b fall=%b busy=%b gcnt=%0d sat=%0d",
                 i, x_clean, rise_pulse, fall_pulse, busy, glitch_cnt, glitch_cnt_s,
                 m_clean, m_rise, m_fall, m_pend != 0, sat(m_glitch, 255), sat(m_glitch, 3));
      end
    end
    rst_n = 1'b1;
    en    = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; x_drv = 1'b0; use_gates = 1'b0;
    a = 1'b1; b = 1'b0; c = 1'b1; d = 1'b1;
    test_reset();
    test_glitch_reject();
    test_clean_toggle();
    test_subcycle_glitch();
    test_enable_abort();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
